// File: rtl/uart_frame_parser_if.sv
// Byte-in / framed-payload-out bundle for uart_frame_parser.
// The slave modport is the parser. The master modport is the UART receiver and payload consumer side.
interface uart_frame_parser_if;
  logic [7:0] uart_data;
  logic       uart_done;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_drop;

  modport slave (
    input  uart_data, uart_done, out_ready,
    output out_data, out_valid, out_last, frame_ok, frame_err, err_code, rx_drop
  );

  modport master (
    output uart_data, uart_done, out_ready,
    input  out_data, out_valid, out_last, frame_ok, frame_err, err_code, rx_drop
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Builds header/len/payload/checksum frames from UART bytes; payload is valid one cycle after the checksum strobe and is held while out_ready is low.
// Bytes that arrive while payload drains are dropped. Optional inter-byte gap timeout: UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int unsigned CLK_FREQ      = 65000000,
  parameter int unsigned UART_BPS      = 115200,
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input logic                sys_clk,
  input logic                sys_rst,
  uart_frame_parser_if.slave bus
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_OUT} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_done_d;
  logic [LW-1:0] r_len;
  logic [7:0]    r_sum;
  logic [IW-1:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]    r_buf [MAX_LEN];
  logic          r_frame_ok, r_frame_err, r_rx_drop;
  logic [1:0]    r_err_code;

  logic       w_byte_stb, w_len_ok, w_out_vld, w_last, w_hs, w_timeout;
  logic       w_ok_nxt, w_err_nxt, w_drop_nxt;
  logic [1:0] w_code_nxt;

  // done_d resets high so a done level held through reset release is not a byte.
  assign w_byte_stb = bus.uart_done & ~r_done_d;
  assign w_len_ok   = (bus.uart_data != 8'd0) && (bus.uart_data <= 8'(MAX_LEN));
  assign w_out_vld  = (r_state == S_OUT);
  assign w_last     = (LW'(r_rd_ptr) == r_len - LW'(1));
  assign w_hs       = w_out_vld & bus.out_ready;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam longint unsigned TO_CYC_L =
    64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_FREQ) / 64'(UART_BPS);
  localparam int unsigned TO_CYC = 32'(TO_CYC_L);
  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  logic [TW-1:0] r_timer;
  logic          w_timing;

  assign w_timing  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  // A byte arriving on the expiry cycle wins and restarts the gap count.
  assign w_timeout = w_timing && !w_byte_stb && (r_timer == TW'(TO_CYC - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_timer <= '0;
    end else if (!w_timing || w_byte_stb || w_timeout) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{CLK_FREQ, UART_BPS, TIMEOUT_BYTES};
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ok_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_drop_nxt  = 1'b0;
    w_code_nxt  = r_err_code;
    unique case (r_state)
      S_IDLE: if (w_byte_stb && bus.uart_data == HEADER) w_state_nxt = S_LEN;
      S_LEN: begin
        if (w_byte_stb) begin
          if (w_len_ok) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
            w_code_nxt  = 2'd1;
          end
        end
      end
      S_DATA: if (w_byte_stb && (LW'(r_wr_ptr) == r_len - LW'(1))) w_state_nxt = S_CSUM;
      S_CSUM: begin
        if (w_byte_stb) begin
          if (bus.uart_data == r_sum) begin
            w_state_nxt = S_OUT;
            w_ok_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
            w_code_nxt  = 2'd2;
          end
        end
      end
      S_OUT: begin
        if (w_hs && w_last) w_state_nxt = S_IDLE;
        w_drop_nxt = w_byte_stb;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err_nxt   = 1'b1;
      w_code_nxt  = 2'd3;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_done_d    <= 1'b1;
      r_len       <= '0;
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'd0;
      r_rx_drop   <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) r_buf[i] <= 8'd0;
    end else begin
      r_done_d    <= bus.uart_done;
      r_frame_ok  <= w_ok_nxt;
      r_frame_err <= w_err_nxt;
      r_err_code  <= w_code_nxt;
      r_rx_drop   <= w_drop_nxt;
      if (w_byte_stb && r_state == S_LEN && w_len_ok) begin
        r_len    <= LW'(bus.uart_data);
        r_sum    <= bus.uart_data;
        r_wr_ptr <= '0;
      end
      if (w_byte_stb && r_state == S_DATA) begin
        r_buf[r_wr_ptr] <= bus.uart_data;
        r_sum           <= r_sum + bus.uart_data;
        r_wr_ptr        <= r_wr_ptr + IW'(1);
      end
      if (w_ok_nxt) begin
        r_rd_ptr <= '0;
      end else if (w_hs) begin
        r_rd_ptr <= r_rd_ptr + IW'(1);
      end
    end
  end

  assign bus.out_valid = w_out_vld;
  assign bus.out_data  = w_out_vld ? r_buf[r_rd_ptr] : 8'd0;
  assign bus.out_last  = w_out_vld & w_last;
  assign bus.frame_ok  = r_frame_ok;
  assign bus.frame_err = r_frame_err;
  assign bus.err_code  = r_err_code;
  assign bus.rx_drop   = r_rx_drop;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: vector table, hand-written corner sequences and random frames checked against a frame-level model.
module tb_uart_frame_parser;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         nb;
    logic [7:0] b[20];
    int         ev;
    int         pst;
    int         plen;
  } vec_t;

  localparam int NV     = 9;
  localparam int TO_CYC = int'(64'd4 * 64'd10 * 64'd65000000 / 64'd115200);

  logic sys_clk = 1'b0;
  logic sys_rst;
  uart_frame_parser_if bus();

  uart_frame_parser u_dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rdy_mode = 0;
  logic       rdy_val  = 1'b0;
  int         ev_q[$];
  logic [8:0] out_q[$];
  int         hs_q[$];
  int         drop_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = '0;
  vec_t       vt[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge sys_clk) cyc++;

  always @(posedge sys_clk) begin
    #2;
    case (rdy_mode)
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      2:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = rdy_val;
    endcase
  end

  // Event/stream monitor; also checks that a stalled output does not change.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (bus.frame_ok) ev_q.push_back(0);
      if (bus.frame_err) ev_q.push_back(int'(bus.err_code));
      if (bus.rx_drop) drop_cnt++;
      if (prev_stall)
        check("stall_hold", 64'({bus.out_valid, bus.out_last, bus.out_data}), 64'({1'b1, prev_out}));
      if (bus.out_valid && bus.out_ready) begin
        out_q.push_back({bus.out_last, bus.out_data});
        hs_q.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_last, bus.out_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_mon();
    ev_q.delete();
    out_q.delete();
    hs_q.delete();
    drop_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge sys_clk);
    #1;
    bus.uart_data = b;
    bus.uart_done = 1'b1;
    repeat (hold) @(posedge sys_clk);
    #1;
    bus.uart_done = 1'b0;
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic send_list(input bq_t bs, input int hold);
    foreach (bs[k]) send_byte(bs[k], hold);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (bus.out_valid && n < 3000);
    check({name, "_drained"}, 64'(bus.out_valid), 64'd0);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic expect_res(input string name, input int ev, input bq_t pl, input bit tp);
    check({name, "_nev"}, 64'(ev_q.size()), (ev < 0) ? 64'd0 : 64'd1);
    if (ev >= 0 && ev_q.size() > 0) check({name, "_ev"}, 64'(ev_q[0]), 64'(ev));
    check({name, "_nout"}, 64'(out_q.size()), 64'(pl.size()));
    for (int i = 0; i < pl.size() && i < out_q.size(); i++)
      check($sformatf("%s_out%0d", name, i), 64'(out_q[i]),
            64'({(i == pl.size() - 1) ? 1'b1 : 1'b0, pl[i]}));
    if (tp)
      for (int i = 1; i < hs_q.size(); i++)
        check($sformatf("%s_tput%0d", name, i), 64'(hs_q[i] - hs_q[0]), 64'(i));
  endtask

  task automatic set_vec(input int i, input int nb, input int ev, input int pst, input int plen,
                         input logic [7:0] b0 = 8'h0, input logic [7:0] b1 = 8'h0,
                         input logic [7:0] b2 = 8'h0, input logic [7:0] b3 = 8'h0,
                         input logic [7:0] b4 = 8'h0, input logic [7:0] b5 = 8'h0);
    vt[i].nb = nb; vt[i].ev = ev; vt[i].pst = pst; vt[i].plen = plen;
    vt[i].b[0] = b0; vt[i].b[1] = b1; vt[i].b[2] = b2;
    vt[i].b[3] = b3; vt[i].b[4] = b4; vt[i].b[5] = b5;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t bs, pl;
    int  t;
    logic [7:0] len, s, p, nz;

    // ev: 0 = frame_ok, 1..3 = error code, -1 = nothing expected.
    set_vec(0, 6, 0, 2, 3, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69);
    set_vec(1, 6, 2, 0, 0, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68);
    set_vec(2, 2, 1, 0, 0, 8'hA5, 8'h00);
    set_vec(3, 2, 1, 0, 0, 8'hA5, 8'h11);
    set_vec(4, 6, 0, 4, 1, 8'h5A, 8'h7E, 8'hA5, 8'h01, 8'hFF, 8'h00);
    set_vec(5, 2, 1, 0, 0, 8'hA5, 8'hA5);
    set_vec(6, 19, 0, 2, 16, 8'hA5, 8'h10);
    for (int k = 0; k < 16; k++) vt[6].b[2 + k] = 8'(k + 1);
    vt[6].b[18] = 8'h98;
    set_vec(7, 4, 0, 2, 1, 8'hA5, 8'h01, 8'h00, 8'h01);
    set_vec(8, 1, -1, 0, 0, 8'h33);

    sys_rst = 1'b1;
    bus.uart_data = 8'h00;
    bus.uart_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_frame_ok", 64'(bus.frame_ok), 64'd0);
    check("rst_frame_err", 64'(bus.frame_err), 64'd0);
    check("rst_err_code", 64'(bus.err_code), 64'd0);
    check("rst_rx_drop", 64'(bus.rx_drop), 64'd0);
    sys_rst = 1'b0;
    rdy_mode = 0;
    rdy_val  = 1'b1;

    for (int v = 0; v < NV; v++) begin
      bs.delete();
      pl.delete();
      for (int k = 0; k < vt[v].nb; k++) bs.push_back(vt[v].b[k]);
      if (vt[v].ev == 0)
        for (int k = 0; k < vt[v].plen; k++) pl.push_back(vt[v].b[vt[v].pst + k]);
      clear_mon();
      send_list(bs, 1);
      wait_drain($sformatf("vec%0d", v));
      expect_res($sformatf("vec%0d", v), vt[v].ev, pl, vt[v].ev == 0);
      if (vt[v].ev > 0)
        check($sformatf("vec%0d_code_hold", v), 64'(bus.err_code), 64'(vt[v].ev));
    end

    // Checksum-to-output latency with the consumer stalled.
    rdy_val = 1'b0;
    repeat (3) @(negedge sys_clk);
    clear_mon();
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h55, 1);
    @(posedge sys_clk);
    #1;
    bus.uart_data = 8'h56;
    bus.uart_done = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("lat_frame_ok", 64'(bus.frame_ok), 64'd1);
    check("lat_out_valid", 64'(bus.out_valid), 64'd1);
    check("lat_out_data", 64'(bus.out_data), 64'h55);
    check("lat_out_last", 64'(bus.out_last), 64'd1);
    bus.uart_done = 1'b0;
    @(negedge sys_clk);
    check("lat_ok_one_cycle", 64'(bus.frame_ok), 64'd0);
    check("lat_valid_held", 64'(bus.out_valid), 64'd1);
    rdy_val = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("lat_valid_after_last", 64'(bus.out_valid), 64'd0);
    pl.delete();
    pl.push_back(8'h55);
    expect_res("lat", 0, pl, 1'b0);

    // Bytes arriving during output (including a header) are dropped; ready then toggles.
    rdy_val = 1'b0;
    repeat (3) @(negedge sys_clk);
    clear_mon();
    bs.delete();
    bs.push_back(8'hA5); bs.push_back(8'h04); bs.push_back(8'hDE);
    bs.push_back(8'hAD); bs.push_back(8'hBE); bs.push_back(8'hEF); bs.push_back(8'h3C);
    send_list(bs, 1);
    send_byte(8'h42, 1);
    send_byte(8'hA5, 1);
    rdy_mode = 2;
    wait_drain("drop");
    pl.delete();
    pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE); pl.push_back(8'hEF);
    expect_res("drop", 0, pl, 1'b0);
    check("drop_count", 64'(drop_cnt), 64'd2);
    rdy_mode = 0;
    rdy_val  = 1'b1;
    clear_mon();
    send_byte(8'h00, 1);
    repeat (4) @(negedge sys_clk);
    check("drop_header_not_taken", 64'(ev_q.size()), 64'd0);

    // Long uart_done levels: one strobe per byte.
    clear_mon();
    bs.delete();
    for (int k = 0; k < 6; k++) bs.push_back(vt[0].b[k]);
    send_list(bs, 300);
    wait_drain("hold300");
    pl.delete();
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    expect_res("hold300", 0, pl, 1'b1);

    // Reset mid-frame discards the partial frame.
    clear_mon();
    send_byte(8'hA5, 1);
    send_byte(8'h03, 1);
    send_byte(8'h11, 1);
    #1;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_quiet", 64'({bus.frame_ok, bus.frame_err, bus.rx_drop, bus.out_valid}), 64'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    send_list(bs, 1);
    wait_drain("rst_mid");
    expect_res("rst_mid", 0, pl, 1'b1);

    // uart_done held high across reset release must not count as a byte.
    clear_mon();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    bus.uart_data = 8'hA5;
    bus.uart_done = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1;
    bus.uart_done = 1'b0;
    send_byte(8'h00, 1);
    repeat (4) @(negedge sys_clk);
    check("rst_release_no_strobe", 64'(ev_q.size()), 64'd0);
    send_list(bs, 1);
    wait_drain("rst_release");
    expect_res("rst_release", 0, pl, 1'b1);

`ifdef UART_FRAME_TIMEOUT_EN
    clear_mon();
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h11, 1);
    repeat (TO_CYC - 50) @(negedge sys_clk);
    check("to_not_early", 64'(ev_q.size()), 64'd0);
    repeat (200) @(negedge sys_clk);
    bs.delete();
    expect_res("timeout", 3, bs, 1'b0);
    check("to_code_hold", 64'(bus.err_code), 64'd3);
    clear_mon();
    bs.delete();
    for (int k = 0; k < 6; k++) bs.push_back(vt[0].b[k]);
    send_list(bs, 1);
    wait_drain("after_to");
    expect_res("after_to", 0, pl, 1'b1);
`else
    clear_mon();
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h11, 1);
    repeat (1000) @(negedge sys_clk);
    check("no_to_waits", 64'(ev_q.size()), 64'd0);
    send_byte(8'h22, 1);
    send_byte(8'h35, 1);
    wait_drain("no_to");
    pl.delete();
    pl.push_back(8'h11); pl.push_back(8'h22);
    expect_res("no_to", 0, pl, 1'b1);
`endif

    // Random frames with random backpressure against the frame-level model.
    rdy_mode = 1;
    for (int f = 0; f < 25; f++) begin
      bs.delete();
      pl.delete();
      repeat ($urandom_range(0, 2)) begin
        nz = 8'($urandom_range(0, 255));
        if (nz == 8'hA5) nz = 8'h5A;
        bs.push_back(nz);
      end
      bs.push_back(8'hA5);
      t = $urandom_range(0, 3);
      if (t == 3) begin
        len = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(17, 255));
        bs.push_back(len);
      end else begin
        len = 8'($urandom_range(1, 16));
        bs.push_back(len);
        s = len;
        for (int k = 0; k < int'(len); k++) begin
          p = 8'($urandom_range(0, 255));
          pl.push_back(p);
          bs.push_back(p);
          s = s + p;
        end
        if (t == 2) begin
          bs.push_back(s + 8'($urandom_range(1, 255)));
          pl.delete();
        end else begin
          bs.push_back(s);
        end
      end
      clear_mon();
      send_list(bs, $urandom_range(1, 4));
      wait_drain($sformatf("rnd%0d", f));
      expect_res($sformatf("rnd%0d", f), (t == 3) ? 1 : (t == 2) ? 2 : 0, pl, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
